// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared constants and state encoding for the pipeline controller
package pipe_ctrl_pkg;

    localparam int STALL_PC  = 0;
    localparam int STALL_IF  = 1;
    localparam int STALL_ID  = 2;
    localparam int STALL_EX  = 3;
    localparam int STALL_MEM = 4;

    localparam int FLUSH_IFID = 0;
    localparam int FLUSH_IDEX = 1;

    localparam logic [4:0] STALL_NONE = 5'b00000;
    localparam logic [4:0] STALL_ALL  = 5'b11111;
    // Load-use: hold everything upstream of execute, bubble into execute
    localparam logic [4:0] STALL_LU   = 5'b00111;

    typedef enum logic [1:0] {
        CTRL_RUN      = 2'd0,
        CTRL_FLUSH    = 2'd1,
        CTRL_MEM_WAIT = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// rtl/pipe_ctrl_hazard_detect.sv - combinational load-use hazard detection
module hazard_detect (
    input  logic       ex_is_load_i,
    input  logic [4:0] ex_reg_waddr_i,
    input  logic [4:0] id_rs1_addr_i,
    input  logic       id_rs1_re_i,
    input  logic [4:0] id_rs2_addr_i,
    input  logic       id_rs2_re_i,
    output logic       lu_o
);

    logic rs1_hit;
    logic rs2_hit;

    // x0 is never a real producer, so a load to x0 cannot create a hazard
    always_comb begin
        rs1_hit = id_rs1_re_i && (id_rs1_addr_i == ex_reg_waddr_i);
        rs2_hit = id_rs2_re_i && (id_rs2_addr_i == ex_reg_waddr_i);
        lu_o    = ex_is_load_i && (ex_reg_waddr_i != 5'd0) && (rs1_hit || rs2_hit);
    end

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/flush/redirect controller with perf counters
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int MEM_TIMEOUT  = 255,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 jump_enable_i,
    input  logic [31:0]          jump_addr_i,
    input  logic [4:0]           id_rs1_addr_i,
    input  logic                 id_rs1_re_i,
    input  logic [4:0]           id_rs2_addr_i,
    input  logic                 id_rs2_re_i,
    input  logic                 ex_is_load_i,
    input  logic [4:0]           ex_reg_waddr_i,
    input  logic                 mem_busy_i,
    output logic [4:0]           stall_o,
    output logic [1:0]           flush_o,
    output logic                 pc_load_o,
    output logic [31:0]          pc_load_addr_o,
    output logic                 bus_err_o,
    output logic [CNT_WIDTH-1:0] stall_cnt_o,
    output logic [CNT_WIDTH-1:0] flush_cnt_o
);

    localparam logic [2:0]  FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [15:0] TMO_MAX    = 16'(MEM_TIMEOUT);

    ctrl_state_t state, state_n;
    logic [2:0]  fcnt, fcnt_n;
    logic [15:0] tcnt, tcnt_n;
    logic        lu;
    logic        jump_acc;
    logic        run_rules;

    hazard_detect u_hazard_detect (
        .ex_is_load_i   (ex_is_load_i),
        .ex_reg_waddr_i (ex_reg_waddr_i),
        .id_rs1_addr_i  (id_rs1_addr_i),
        .id_rs1_re_i    (id_rs1_re_i),
        .id_rs2_addr_i  (id_rs2_addr_i),
        .id_rs2_re_i    (id_rs2_re_i),
        .lu_o           (lu)
    );

    // Next-state and Mealy outputs; priority is mem_busy > jump > load-use
    always_comb begin
        state_n        = state;
        fcnt_n         = fcnt;
        tcnt_n         = tcnt;
        stall_o        = STALL_NONE;
        flush_o        = 2'b00;
        pc_load_o      = 1'b0;
        pc_load_addr_o = 32'd0;
        jump_acc       = 1'b0;
        // MEM_WAIT falls through to RUN handling on the cycle memory completes
        run_rules      = (state == CTRL_RUN) || (state == CTRL_MEM_WAIT && !mem_busy_i);

        case (state)
            CTRL_FLUSH: begin
                if (mem_busy_i) begin
                    stall_o = STALL_ALL;
                end else begin
                    flush_o[FLUSH_IFID] = 1'b1;
                    flush_o[FLUSH_IDEX] = 1'b1;
                    fcnt_n              = fcnt - 3'd1;
                    if (fcnt == 3'd1) begin
                        state_n = CTRL_RUN;
                    end
                end
            end
            CTRL_MEM_WAIT: begin
                if (mem_busy_i) begin
                    stall_o = STALL_ALL;
                    if (tcnt != TMO_MAX) begin
                        tcnt_n = tcnt + 16'd1;
                    end
                end else begin
                    tcnt_n  = 16'd0;
                    state_n = CTRL_RUN;
                end
            end
            default: begin
                if (mem_busy_i) begin
                    stall_o = STALL_ALL;
                    state_n = CTRL_MEM_WAIT;
                    tcnt_n  = 16'd1;
                end
            end
        endcase

        if (run_rules && !mem_busy_i) begin
            if (jump_enable_i) begin
                pc_load_o           = 1'b1;
                pc_load_addr_o      = jump_addr_i;
                flush_o[FLUSH_IFID] = 1'b1;
                flush_o[FLUSH_IDEX] = 1'b1;
                jump_acc            = 1'b1;
                if (FLUSH_CYCLES > 1) begin
                    state_n = CTRL_FLUSH;
                    fcnt_n  = FLUSH_LOAD;
                end
            end else if (lu) begin
                stall_o             = STALL_LU;
                flush_o[FLUSH_IDEX] = 1'b1;
            end
        end

        if (rst_i) begin
            stall_o        = STALL_NONE;
            flush_o        = 2'b00;
            pc_load_o      = 1'b0;
            pc_load_addr_o = 32'd0;
            jump_acc       = 1'b0;
        end
    end

    // State, counters and sticky timeout flag
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= CTRL_RUN;
            fcnt        <= 3'd0;
            tcnt        <= 16'd0;
            bus_err_o   <= 1'b0;
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            state     <= state_n;
            fcnt      <= fcnt_n;
            tcnt      <= tcnt_n;
            bus_err_o <= bus_err_o || (tcnt_n == TMO_MAX);
            if (stall_o != STALL_NONE) begin
                stall_cnt_o <= stall_cnt_o + 1'b1;
            end
            if (jump_acc) begin
                flush_cnt_o <= flush_cnt_o + 1'b1;
            end
        end
    end

endmodule
